// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: shares one external combinational ALU between two requesters.
//
// Round-robin arbitration in IDLE. The granted operands are registered onto alu_*,
// so the ALU sees stable inputs for the whole ISSUE cycle. The result and zero flag
// are captured into rsp_* at the end of ISSUE and returned with the requester ID
// under a valid/ready handshake. NZCV is updated only when the ALU asks for it.
//
// Configuration macro:
//   ALU_ARB_FIXED_PRIO_EN  defined: req0 always wins ties (req1 may starve).
//                          undefined (default): round-robin using last_grant.
//
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   reqX_valid/ready/a/b/ctrl    X=0,1 request channels (ctrl passed through)
//   alu_a, alu_b, alu_ctrl       registered operands to the ALU
//   alu_result, alu_zero,
//   alu_negative, alu_carry,
//   alu_overflow, alu_write_flags  results and flags from the ALU
//   rsp_valid/ready/id/result/zero response channel
//   nzcv                         architectural flags {N,Z,C,V}
module alu_share_arbiter #(
    parameter int unsigned N = 64
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [N-1:0] req0_a,
    input  logic [N-1:0] req0_b,
    input  logic [3:0]   req0_ctrl,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [N-1:0] req1_a,
    input  logic [N-1:0] req1_b,
    input  logic [3:0]   req1_ctrl,
    output logic [N-1:0] alu_a,
    output logic [N-1:0] alu_b,
    output logic [3:0]   alu_ctrl,
    input  logic [N-1:0] alu_result,
    input  logic         alu_zero,
    input  logic         alu_negative,
    input  logic         alu_carry,
    input  logic         alu_overflow,
    input  logic         alu_write_flags,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic         rsp_id,
    output logic [N-1:0] rsp_result,
    output logic         rsp_zero,
    output logic [3:0]   nzcv
);

    typedef enum logic [1:0] {StIdle, StIssue, StResp} state_e;

    state_e       state_q, state_d;
    logic         grant1;
    logic         accept;
    logic [N-1:0] alu_a_q, alu_b_q;
    logic [3:0]   alu_ctrl_q;
    logic         id_q;
    logic [N-1:0] rsp_result_q;
    logic         rsp_zero_q;
    logic [3:0]   nzcv_q;
`ifndef ALU_ARB_FIXED_PRIO_EN
    logic         last_grant_q;
`endif

    // grant1=1 selects req1; only meaningful when at least one requester is valid.
    always_comb begin
        grant1 = 1'b0;
`ifdef ALU_ARB_FIXED_PRIO_EN
        grant1 = req1_valid & ~req0_valid;
`else
        if (req0_valid && req1_valid) begin
            grant1 = ~last_grant_q;
        end else begin
            grant1 = req1_valid;
        end
`endif
    end

    always_comb begin
        state_d    = state_q;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        accept     = 1'b0;
        unique case (state_q)
            StIdle: begin
                req0_ready = req0_valid & ~grant1;
                req1_ready = grant1;
                accept     = req0_valid | req1_valid;
                if (accept) begin
                    state_d = StIssue;
                end
            end
            StIssue: state_d = StResp;
            // No accept here even on the handshake cycle; IDLE must be re-entered first.
            StResp: begin
                if (rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_ctrl_q   <= '0;
            id_q         <= 1'b0;
            rsp_result_q <= '0;
            rsp_zero_q   <= 1'b0;
            nzcv_q       <= '0;
        end else begin
            state_q <= state_d;
            // alu_* keep their last values outside ISSUE to avoid needless toggling.
            if (accept) begin
                alu_a_q    <= grant1 ? req1_a : req0_a;
                alu_b_q    <= grant1 ? req1_b : req0_b;
                alu_ctrl_q <= grant1 ? req1_ctrl : req0_ctrl;
                id_q       <= grant1;
            end
            if (state_q == StIssue) begin
                rsp_result_q <= alu_result;
                rsp_zero_q   <= alu_zero;
                if (alu_write_flags) begin
                    nzcv_q <= {alu_negative, (alu_result == '0), alu_carry, alu_overflow};
                end
            end
        end
    end

`ifndef ALU_ARB_FIXED_PRIO_EN
    // Reset to 1 so req0 wins the first tie.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_grant_q <= 1'b1;
        end else if (accept) begin
            last_grant_q <= grant1;
        end
    end
`endif

    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_ctrl   = alu_ctrl_q;
    assign rsp_valid  = (state_q == StResp);
    assign rsp_id     = id_q;
    assign rsp_result = rsp_result_q;
    assign rsp_zero   = rsp_zero_q;
    assign nzcv       = nzcv_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter: vector table of single transactions,
// hand-written multi-cycle sequences, and a randomized run against a transaction model.
module tb_alu_share_arbiter;

    localparam int unsigned N = 64;

    typedef struct packed {
        logic [N-1:0] res;
        logic         n, z, c, v, wf;
    } alu_out_t;

    // Stand-in ALU: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 PASS b,
    // 1010 ADDS, 1110 SUBS (flag setting); anything else returns 0, no flags.
    function automatic alu_out_t alu_fn(input logic [N-1:0] a, input logic [N-1:0] b,
                                        input logic [3:0] ctrl);
        alu_out_t   o;
        logic [N:0] s;
        o = '0;
        s = '0;
        case (ctrl)
            4'b0000: o.res = a & b;
            4'b0001: o.res = a | b;
            4'b0010: o.res = a + b;
            4'b0110: o.res = a - b;
            4'b0111: o.res = b;
            4'b1010: begin
                s     = {1'b0, a} + {1'b0, b};
                o.res = s[N-1:0];
                o.c   = s[N];
                o.v   = (a[N-1] == b[N-1]) && (o.res[N-1] != a[N-1]);
                o.wf  = 1'b1;
            end
            4'b1110: begin
                s     = {1'b0, a} + {1'b0, ~b} + {{N{1'b0}}, 1'b1};
                o.res = s[N-1:0];
                o.c   = s[N];
                o.v   = (a[N-1] != b[N-1]) && (o.res[N-1] != a[N-1]);
                o.wf  = 1'b1;
            end
            default: o.res = '0;
        endcase
        o.n = o.res[N-1];
        o.z = (o.res == '0);
        return o;
    endfunction

    logic         clk = 1'b0;
    logic         reset_n;
    logic         req0_valid, req0_ready, req1_valid, req1_ready;
    logic [N-1:0] req0_a, req0_b, req1_a, req1_b;
    logic [3:0]   req0_ctrl, req1_ctrl;
    logic [N-1:0] alu_a, alu_b, alu_result;
    logic [3:0]   alu_ctrl;
    logic         alu_zero, alu_negative, alu_carry, alu_overflow, alu_write_flags;
    logic         rsp_valid, rsp_ready, rsp_id, rsp_zero;
    logic [N-1:0] rsp_result;
    logic [3:0]   nzcv;
    alu_out_t     ao;

    always #5 clk = ~clk;

    assign ao              = alu_fn(alu_a, alu_b, alu_ctrl);
    assign alu_result      = ao.res;
    assign alu_zero        = ao.z;
    assign alu_negative    = ao.n;
    assign alu_carry       = ao.c;
    assign alu_overflow    = ao.v;
    assign alu_write_flags = ao.wf;

    alu_share_arbiter #(.N(N)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .req0_valid     (req0_valid),
        .req0_ready     (req0_ready),
        .req0_a         (req0_a),
        .req0_b         (req0_b),
        .req0_ctrl      (req0_ctrl),
        .req1_valid     (req1_valid),
        .req1_ready     (req1_ready),
        .req1_a         (req1_a),
        .req1_b         (req1_b),
        .req1_ctrl      (req1_ctrl),
        .alu_a          (alu_a),
        .alu_b          (alu_b),
        .alu_ctrl       (alu_ctrl),
        .alu_result     (alu_result),
        .alu_zero       (alu_zero),
        .alu_negative   (alu_negative),
        .alu_carry      (alu_carry),
        .alu_overflow   (alu_overflow),
        .alu_write_flags(alu_write_flags),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_id         (rsp_id),
        .rsp_result     (rsp_result),
        .rsp_zero       (rsp_zero),
        .nzcv           (nzcv)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [N-1:0] got, input logic [N-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic idle_reqs();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    task automatic set_req(input logic id, input logic [N-1:0] a, input logic [N-1:0] b,
                           input logic [3:0] ctrl);
        if (id) begin
            req1_valid = 1'b1; req1_a = a; req1_b = b; req1_ctrl = ctrl;
        end else begin
            req0_valid = 1'b1; req0_a = a; req0_b = b; req0_ctrl = ctrl;
        end
    endtask

    // Waits (bounded) at negedges for the given requester's ready; returns accept cycle.
    task automatic wait_accept(input logic id, output bit got, output int at);
        got = 0;
        at  = -1;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            if (id ? req1_ready : req0_ready) begin
                got = 1;
                at  = cyc;
            end
        end
    endtask

    task automatic wait_rsp(output bit got);
        got = 0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            if (rsp_valid) got = 1;
        end
    endtask

    task automatic do_reset();
        idle_reqs();
        rsp_ready = 1'b0;
        @(posedge clk);
        #2 reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic         id;
        logic [N-1:0] a, b;
        logic [3:0]   ctrl;
        logic [N-1:0] res;
        logic         zero;
        logic [3:0]   nzcv;
    } vec_t;

    vec_t vecs[8];

    task automatic run_vec(input int k, input vec_t v);
        bit got;
        int at;
        set_req(v.id, v.a, v.b, v.ctrl);
        rsp_ready = 1'b1;
        wait_accept(v.id, got, at);
        check($sformatf("vec%0d_accept", k), N'(got), N'(1));
        @(posedge clk);
        #1 idle_reqs();
        if (got) begin
            wait_rsp(got);
            check($sformatf("vec%0d_rsp_valid", k), N'(got), N'(1));
            check($sformatf("vec%0d_latency", k), N'(cyc - at), N'(2));
            check($sformatf("vec%0d_rsp_id", k), N'(rsp_id), N'(v.id));
            check($sformatf("vec%0d_result", k), rsp_result, v.res);
            check($sformatf("vec%0d_zero", k), N'(rsp_zero), N'(v.zero));
            check($sformatf("vec%0d_nzcv", k), N'(nzcv), N'(v.nzcv));
            @(posedge clk);
            #1;
        end
    endtask

    typedef struct {
        logic         id;
        logic [N-1:0] res;
        logic         zero;
        logic [3:0]   nzcv;
        int           ready_at;
    } exp_t;

    initial begin
        bit           got;
        int           at;
        int           gid[4];
        int           gcy[4];
        int           ng;
        bit           bad;
        exp_t         q[$];
        exp_t         e;
        alu_out_t     r;
        logic         lg;
        logic         g;
        logic         e0, e1, rv;
        logic [3:0]   m_nzcv;
        logic [3:0]   ctrls[8];

        vecs[0] = '{1'b0, 64'd5, 64'd3, 4'b0010, 64'd8, 1'b0, 4'b0000};
        vecs[1] = '{1'b1, 64'd3, 64'd5, 4'b1110, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 4'b1000};
        vecs[2] = '{1'b0, 64'd9, 64'd0, 4'b0111, 64'd0, 1'b1, 4'b1000};
        vecs[3] = '{1'b1, 64'd7, 64'd7, 4'b1110, 64'd0, 1'b1, 4'b0110};
        vecs[4] = '{1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 4'b1010,
                    64'h8000_0000_0000_0000, 1'b0, 4'b1001};
        vecs[5] = '{1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 4'b1010, 64'd0, 1'b1, 4'b0110};
        vecs[6] = '{1'b0, 64'd1, 64'd2, 4'b1111, 64'd0, 1'b1, 4'b0110};
        vecs[7] = '{1'b1, 64'hF0, 64'h3C, 4'b0000, 64'h30, 1'b0, 4'b0110};

        ctrls = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1010, 4'b1110, 4'b1011};

        reset_n   = 1'b0;
        rsp_ready = 1'b0;
        idle_reqs();
        req0_a = '0; req0_b = '0; req0_ctrl = '0;
        req1_a = '0; req1_b = '0; req1_ctrl = '0;
        #12;
        check("reset_rsp_valid", N'(rsp_valid), N'(0));
        check("reset_nzcv", N'(nzcv), N'(0));
        check("reset_alu_a", alu_a, N'(0));
        check("reset_alu_ctrl", N'(alu_ctrl), N'(0));
        check("reset_rsp_result", rsp_result, N'(0));
        check("reset_ready", N'({req1_ready, req0_ready}), N'(0));
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        for (int k = 0; k < 8; k++) run_vec(k, vecs[k]);

        // Back-pressured response: rsp_* stable, nothing accepted while waiting.
        rsp_ready = 1'b0;
        set_req(1'b0, 64'd10, 64'd20, 4'b0010);
        wait_accept(1'b0, got, at);
        check("bp_accept", N'(got), N'(1));
        @(posedge clk);
        #1 idle_reqs();
        set_req(1'b1, 64'd1, 64'd2, 4'b1110);
        wait_rsp(got);
        check("bp_rsp_valid", N'(got), N'(1));
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            check("bp_hold_valid", N'(rsp_valid), N'(1));
            check("bp_hold_result", rsp_result, N'(30));
            check("bp_hold_id", N'(rsp_id), N'(0));
            check("bp_hold_ready", N'({req1_ready, req0_ready}), N'(0));
        end
        @(posedge clk);
        #1 rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_hs_valid", N'(rsp_valid), N'(1));
        check("bp_hs_no_accept", N'({req1_ready, req0_ready}), N'(0));
        @(negedge clk);
        check("bp_after_valid", N'(rsp_valid), N'(0));
        check("bp_after_ready1", N'(req1_ready), N'(1));
        @(posedge clk);
        #1 idle_reqs();
        wait_rsp(got);
        check("bp2_rsp_valid", N'(got), N'(1));
        check("bp2_result", rsp_result, 64'hFFFF_FFFF_FFFF_FFFF);
        check("bp2_id", N'(rsp_id), N'(1));
        check("bp2_nzcv", N'(nzcv), N'(4'b1000));
        @(posedge clk);
        #1;

        // Reset during ISSUE drops the transaction and clears flags.
        set_req(1'b1, 64'd5, 64'd9, 4'b1110);
        wait_accept(1'b1, got, at);
        check("rst_accept", N'(got), N'(1));
        @(posedge clk);
        #2 reset_n = 1'b0;
        idle_reqs();
        #1;
        check("rst_rsp_valid", N'(rsp_valid), N'(0));
        check("rst_nzcv", N'(nzcv), N'(0));
        @(negedge clk);
        reset_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (rsp_valid) bad = 1;
        end
        check("rst_no_response", N'(bad), N'(0));
        check("rst_nzcv_after", N'(nzcv), N'(0));

        // Both requesters held valid: grant order and accept spacing.
        @(posedge clk);
        #1;
        set_req(1'b0, 64'd1, 64'd2, 4'b0010);
        set_req(1'b1, 64'd3, 64'd4, 4'b0010);
        rsp_ready = 1'b1;
        ng = 0;
        for (int k = 0; k < 4; k++) begin
            gid[k] = -1;
            gcy[k] = -100;
        end
        for (int i = 0; i < 40 && ng < 4; i++) begin
            @(negedge clk);
            if (req0_ready || req1_ready) begin
                gid[ng] = int'(req1_ready);
                gcy[ng] = cyc;
                ng++;
            end
        end
        @(posedge clk);
        #1 idle_reqs();
        check("tie_grant_count", N'(ng), N'(4));
        for (int k = 0; k < 4; k++) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
            check($sformatf("tie_grant%0d", k), N'(gid[k]), N'(0));
`else
            check($sformatf("tie_grant%0d", k), N'(gid[k]), N'(k % 2));
`endif
            if (k > 0) check($sformatf("tie_spacing%0d", k), N'(gcy[k] - gcy[k-1]), N'(3));
        end
        repeat (4) @(posedge clk);
        #1;

        // Randomized run against a transaction-level model.
        do_reset();
        q.delete();
        lg     = 1'b1;
        m_nzcv = 4'b0000;
        for (int i = 0; i < 400; i++) begin
            if (i < 385) begin
                req0_valid = 1'($urandom_range(0, 1));
                req1_valid = 1'($urandom_range(0, 1));
                req0_a     = ($urandom_range(0, 2) == 0) ? N'($urandom_range(0, 3))
                                                         : {$urandom, $urandom};
                req0_b     = ($urandom_range(0, 3) == 0) ? req0_a : {$urandom, $urandom};
                req1_a     = ($urandom_range(0, 2) == 0) ? N'($urandom_range(0, 3))
                                                         : {$urandom, $urandom};
                req1_b     = ($urandom_range(0, 3) == 0) ? req1_a : {$urandom, $urandom};
                req0_ctrl  = ctrls[$urandom_range(0, 7)];
                req1_ctrl  = ctrls[$urandom_range(0, 7)];
                rsp_ready  = ($urandom_range(0, 3) != 0);
            end else begin
                idle_reqs();
                rsp_ready = 1'b1;
            end
            @(negedge clk);
            e0 = 1'b0;
            e1 = 1'b0;
            g  = 1'b0;
            if (q.size() == 0) begin
                if (req0_valid && req1_valid) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
                    g = 1'b0;
`else
                    g = ~lg;
`endif
                end else begin
                    g = req1_valid;
                end
                if (req0_valid || req1_valid) begin
                    e1 = g;
                    e0 = ~g;
                end
            end
            check("rnd_ready", N'({req1_ready, req0_ready}), N'({e1, e0}));
            rv = (q.size() > 0) && (cyc >= q[0].ready_at);
            check("rnd_rsp_valid", N'(rsp_valid), N'(rv));
            if (rv) begin
                check("rnd_rsp_id", N'(rsp_id), N'(q[0].id));
                check("rnd_result", rsp_result, q[0].res);
                check("rnd_zero", N'(rsp_zero), N'(q[0].zero));
                check("rnd_nzcv", N'(nzcv), N'(q[0].nzcv));
            end else if (q.size() == 0) begin
                check("rnd_nzcv_idle", N'(nzcv), N'(m_nzcv));
            end
            if (rv && rsp_ready) begin
                void'(q.pop_front());
            end else if (e0 || e1) begin
                r = g ? alu_fn(req1_a, req1_b, req1_ctrl) : alu_fn(req0_a, req0_b, req0_ctrl);
                if (r.wf) m_nzcv = {r.n, r.z, r.c, r.v};
                e.id       = g;
                e.res      = r.res;
                e.zero     = r.z;
                e.nzcv     = m_nzcv;
                e.ready_at = cyc + 2;
                q.push_back(e);
                lg = g;
            end
            @(posedge clk);
            #1;
        end
        check("rnd_drained", N'(q.size()), N'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
